mipi_dphy_lp_hs_tx: RTL and testbench

//  Transmit-side D-PHY data-lane sequencer: drives the single-ended LP pair and a parallel HS byte stream.

---
 rtl/mipi_dphy_lp_hs_tx_if.sv | 39 +++
 rtl/mipi_dphy_lp_hs_tx.sv | 190 +++++++++++++++++++
 tb/tb_mipi_dphy_lp_hs_tx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_dphy_lp_hs_tx_if.sv
// -----------------------------------------------------------------------------
// mipi_dphy_lp_hs_tx_if
//   Byte-stream handshake between the upstream packetizer and the D-PHY
//   data-lane transmit sequencer.
//
//   Signals
//     TX_REQ    start-of-burst request (packetizer -> sequencer)
//     TX_DATA   8-bit payload byte     (packetizer -> sequencer)
//     TX_VALID  TX_DATA valid          (packetizer -> sequencer)
//     TX_LAST   final byte of burst    (packetizer -> sequencer)
//     TX_READY  byte accepted          (sequencer  -> packetizer)
//
//   Modports
//     master : packetizer side
//     slave  : sequencer side
// -----------------------------------------------------------------------------
interface mipi_dphy_lp_hs_tx_if;
    logic       TX_REQ;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_LAST;
    logic       TX_READY;

    modport master (
        output TX_REQ,
        output TX_DATA,
        output TX_VALID,
        output TX_LAST,
        input  TX_READY
    );

    modport slave (
        input  TX_REQ,
        input  TX_DATA,
        input  TX_VALID,
        input  TX_LAST,
        output TX_READY
    );
endinterface

// File: rtl/mipi_dphy_lp_hs_tx.sv
// -----------------------------------------------------------------------------
// mipi_dphy_lp_hs_tx
//   Transmit-side D-PHY data-lane sequencer. Drives the single-ended LP pair
//   and a parallel HS byte stream, producing the HS-entry handshake
//   LP-11 -> LP-01 -> LP-00, then HS-zero, sync byte 0xB8, payload,
//   HS-trail, and a forced LP-11 exit period before returning to stop.
//
//   Ports
//     CLK        byte clock
//     RESET_n    asynchronous, active-low reset
//     tx         byte-stream handshake (slave modport of mipi_dphy_lp_hs_tx_if)
//     LP_P/LP_N  LP driver lines (registered)
//     HS_EN      HS driver enable (registered)
//     HS_DATA    HS byte to serializer, LSB first (registered)
//     HS_MODE    lane in HS state, prepare through trail (registered)
//     BUSY       sequencer not in stop state
//     UNDERFLOW  sticky payload-underflow flag (optional, see below)
//
//   Build option
//     MIPI_LP_HS_TX_UNDERFLOW_EN : adds the UNDERFLOW output. It is set when
//     the burst ends because TX_VALID dropped in the data phase, and cleared
//     by reset or by the next accepted TX_REQ.
// -----------------------------------------------------------------------------
module mipi_dphy_lp_hs_tx #(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 4,
    parameter int T_HS_ZERO    = 8,
    parameter int T_HS_TRAIL   = 6,
    parameter int T_HS_EXIT    = 6
) (
    input  logic                       CLK,
    input  logic                       RESET_n,
    mipi_dphy_lp_hs_tx_if.slave        tx,
    output logic                       LP_P,
    output logic                       LP_N,
    output logic                       HS_EN,
    output logic [7:0]                 HS_DATA,
    output logic                       HS_MODE,
    output logic                       BUSY
`ifdef MIPI_LP_HS_TX_UNDERFLOW_EN
    ,
    output logic                       UNDERFLOW
`endif
);

    localparam int MAX_AB  = (T_LPX > T_HS_PREPARE) ? T_LPX : T_HS_PREPARE;
    localparam int MAX_CD  = (T_HS_ZERO > T_HS_TRAIL) ? T_HS_ZERO : T_HS_TRAIL;
    localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int MAX_T   = (MAX_ABC > T_HS_EXIT) ? MAX_ABC : T_HS_EXIT;
    localparam int CNT_W   = $clog2(MAX_T) + 1;

    // ST_LAST shows the final accepted byte on HS_DATA while refusing further
    // bytes, so trail always begins right after the last driven byte.
    typedef enum logic [3:0] {
        ST_STOP,
        ST_RQST,
        ST_PREP,
        ST_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_LAST,
        ST_TRAIL,
        ST_EXIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_b7;   // bit 7 of the most recent byte driven

    assign tx.TX_READY = (state == ST_DATA);
    assign BUSY        = (state != ST_STOP);

    // Outputs are updated on the transition into a state, so each output
    // register always reflects the state being entered. Only fields that
    // change on a given transition are assigned.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= ST_STOP;
            cnt     <= '0;
            LP_P    <= 1'b1;
            LP_N    <= 1'b1;
            HS_EN   <= 1'b0;
            HS_DATA <= 8'h00;
            HS_MODE <= 1'b0;
            last_b7 <= 1'b1;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (tx.TX_REQ) begin
                        state <= ST_RQST;
                        cnt   <= CNT_W'(T_LPX - 1);
                        LP_P  <= 1'b0;
                    end
                end
                ST_RQST: begin
                    if (cnt == '0) begin
                        state   <= ST_PREP;
                        cnt     <= CNT_W'(T_HS_PREPARE - 1);
                        LP_N    <= 1'b0;
                        HS_MODE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PREP: begin
                    if (cnt == '0) begin
                        state   <= ST_ZERO;
                        cnt     <= CNT_W'(T_HS_ZERO - 1);
                        HS_EN   <= 1'b1;
                        HS_DATA <= 8'h00;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ZERO: begin
                    if (cnt == '0) begin
                        state   <= ST_SYNC;
                        HS_DATA <= 8'hB8;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SYNC: begin
                    // No byte has been accepted yet on the first data cycle;
                    // the line carries 0x00 there. The sync byte counts as the
                    // last driven byte until payload arrives.
                    state   <= ST_DATA;
                    HS_DATA <= 8'h00;
                    last_b7 <= 1'b1;
                end
                ST_DATA: begin
                    if (tx.TX_VALID) begin
                        HS_DATA <= tx.TX_DATA;
                        last_b7 <= tx.TX_DATA[7];
                        if (tx.TX_LAST) begin
                            state <= ST_LAST;
                        end
                    end else begin
                        state   <= ST_TRAIL;
                        cnt     <= CNT_W'(T_HS_TRAIL - 1);
                        HS_DATA <= {8{~last_b7}};
                    end
                end
                ST_LAST: begin
                    state   <= ST_TRAIL;
                    cnt     <= CNT_W'(T_HS_TRAIL - 1);
                    HS_DATA <= {8{~last_b7}};
                end
                ST_TRAIL: begin
                    if (cnt == '0) begin
                        state   <= ST_EXIT;
                        cnt     <= CNT_W'(T_HS_EXIT - 1);
                        LP_P    <= 1'b1;
                        LP_N    <= 1'b1;
                        HS_EN   <= 1'b0;
                        HS_MODE <= 1'b0;
                        HS_DATA <= 8'h00;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_EXIT: begin
                    // TX_REQ is deliberately not looked at here; a held
                    // request is taken on the first stop cycle.
                    if (cnt == '0) begin
                        state <= ST_STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_STOP;
                end
            endcase
        end
    end

`ifdef MIPI_LP_HS_TX_UNDERFLOW_EN
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            UNDERFLOW <= 1'b0;
        end else if ((state == ST_STOP) && tx.TX_REQ) begin
            UNDERFLOW <= 1'b0;
        end else if ((state == ST_DATA) && !tx.TX_VALID) begin
            UNDERFLOW <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mipi_dphy_lp_hs_tx.sv
// -----------------------------------------------------------------------------
// tb_mipi_dphy_lp_hs_tx
//   Directed bench for mipi_dphy_lp_hs_tx: reset/idle behaviour, full bursts
//   ending with TX_LAST, underflow-terminated bursts (including zero payload),
//   a request held through exit, and reset asserted during the data phase.
//   Payload and trail bytes are pushed to a scoreboard queue as they are
//   offered and popped when they are due on HS_DATA.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mipi_dphy_lp_hs_tx;

    localparam int LPX   = 4;
    localparam int PREP  = 4;
    localparam int ZERO  = 8;
    localparam int TRAIL = 6;
    localparam int EXIT  = 6;

    // Cycle indices relative to the cycle in which TX_REQ is presented (0).
    localparam int RQ_END   = LPX;
    localparam int PREP_END = LPX + PREP;
    localparam int SYNC_C   = PREP_END + ZERO + 1;

    logic       CLK = 1'b0;
    logic       RESET_n = 1'b0;
    logic       LP_P;
    logic       LP_N;
    logic       HS_EN;
    logic [7:0] HS_DATA;
    logic       HS_MODE;
    logic       BUSY;
`ifdef MIPI_LP_HS_TX_UNDERFLOW_EN
    logic       UNDERFLOW;
`endif

    logic       exp_uf = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];

    mipi_dphy_lp_hs_tx_if bus ();

    mipi_dphy_lp_hs_tx #(
        .T_LPX        (LPX),
        .T_HS_PREPARE (PREP),
        .T_HS_ZERO    (ZERO),
        .T_HS_TRAIL   (TRAIL),
        .T_HS_EXIT    (EXIT)
    ) u_dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .tx      (bus.slave),
        .LP_P    (LP_P),
        .LP_N    (LP_N),
        .HS_EN   (HS_EN),
        .HS_DATA (HS_DATA),
        .HS_MODE (HS_MODE),
        .BUSY    (BUSY)
`ifdef MIPI_LP_HS_TX_UNDERFLOW_EN
        ,
        .UNDERFLOW (UNDERFLOW)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks += 1;
        assert (obs === exp) else begin
            failures += 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks += 1;
        assert (obs === exp) else begin
            failures += 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks += 1;
        assert (obs === exp) else begin
            failures += 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks += 1;
            failures += 1;
            $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, HS_DATA);
        end else begin
            e = exp_q.pop_front();
            chk8(tag, HS_DATA, e);
        end
    endtask

    task automatic chk_uf(input string tag);
`ifdef MIPI_LP_HS_TX_UNDERFLOW_EN
        chk1(tag, UNDERFLOW, exp_uf);
`else
        checks += 0;
`endif
    endtask

    // Runs one burst with payload pl_q. Entered in the drive slot of a stop
    // cycle; returns in the drive slot of the stop cycle following exit.
    task automatic burst(input bit end_last, input bit hold_req);
        logic b7;
        int   n;
        b7 = 1'b1;
        n  = pl_q.size();
        bus.TX_REQ = 1'b1;
        smp();
        chk2("c0_lp", {LP_P, LP_N}, 2'b11);
        chk1("c0_busy", BUSY, 1'b0);
        chk_uf("c0_uf");
        adv();
        if (!hold_req) bus.TX_REQ = 1'b0;
        exp_uf = 1'b0;
        for (int c = 1; c <= SYNC_C; c++) begin
            smp();
            chk2("entry_lp", {LP_P, LP_N}, (c <= RQ_END) ? 2'b01 : 2'b00);
            chk1("entry_hs_en", HS_EN, (c > PREP_END));
            chk1("entry_hs_mode", HS_MODE, (c > RQ_END));
            chk8("entry_hs_data", HS_DATA, (c == SYNC_C) ? 8'hB8 : 8'h00);
            chk1("entry_ready", bus.TX_READY, 1'b0);
            chk1("entry_busy", BUSY, 1'b1);
            chk_uf("entry_uf");
            adv();
        end
        for (int i = 0; i < n; i++) begin
            bus.TX_VALID = 1'b1;
            bus.TX_DATA  = pl_q[i];
            bus.TX_LAST  = end_last && (i == n - 1);
            smp();
            chk1("data_ready", bus.TX_READY, 1'b1);
            chk1("data_hs_en", HS_EN, 1'b1);
            chk2("data_lp", {LP_P, LP_N}, 2'b00);
            if (i > 0) chk_pop("data_byte");
            exp_q.push_back(pl_q[i]);
            b7 = pl_q[i][7];
            adv();
        end
        bus.TX_VALID = 1'b0;
        bus.TX_LAST  = 1'b0;
        bus.TX_DATA  = 8'hEE;
        smp();
        chk1("end_ready", bus.TX_READY, !end_last);
        if (n > 0) chk_pop("final_byte");
        adv();
        for (int t = 0; t < TRAIL; t++) exp_q.push_back({8{~b7}});
        exp_uf = !end_last;
        for (int t = 0; t < TRAIL; t++) begin
            smp();
            chk_pop("trail_byte");
            chk2("trail_lp", {LP_P, LP_N}, 2'b00);
            chk1("trail_hs_en", HS_EN, 1'b1);
            chk1("trail_hs_mode", HS_MODE, 1'b1);
            chk1("trail_ready", bus.TX_READY, 1'b0);
            chk_uf("trail_uf");
            adv();
        end
        for (int t = 0; t < EXIT; t++) begin
            smp();
            chk2("exit_lp", {LP_P, LP_N}, 2'b11);
            chk1("exit_hs_en", HS_EN, 1'b0);
            chk1("exit_hs_mode", HS_MODE, 1'b0);
            chk8("exit_hs_data", HS_DATA, 8'h00);
            chk1("exit_busy", BUSY, 1'b1);
            chk_uf("exit_uf");
            adv();
        end
    endtask

    initial begin
        bus.TX_REQ   = 1'b0;
        bus.TX_DATA  = 8'h00;
        bus.TX_VALID = 1'b0;
        bus.TX_LAST  = 1'b0;
        RESET_n      = 1'b0;
        repeat (3) adv();

        smp();
        chk2("rst_lp", {LP_P, LP_N}, 2'b11);
        chk1("rst_hs_en", HS_EN, 1'b0);
        chk8("rst_hs_data", HS_DATA, 8'h00);
        chk1("rst_hs_mode", HS_MODE, 1'b0);
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_ready", bus.TX_READY, 1'b0);
        chk_uf("rst_uf");
        adv();
        RESET_n = 1'b1;

        // Idle with a stray byte offered: it must not be taken.
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            smp();
            chk2("idle_lp", {LP_P, LP_N}, 2'b11);
            chk1("idle_hs_en", HS_EN, 1'b0);
            chk8("idle_hs_data", HS_DATA, 8'h00);
            chk1("idle_busy", BUSY, 1'b0);
            chk1("idle_ready", bus.TX_READY, 1'b0);
            adv();
        end
        bus.TX_VALID = 1'b0;

        pl_q = {8'h11, 8'h22, 8'h83};
        burst(1'b1, 1'b0);

        pl_q = {8'h7F};
        burst(1'b1, 1'b0);

        // Underflow after two bytes, request held high through exit.
        pl_q = {8'h05, 8'h1A};
        burst(1'b0, 1'b1);

        // Held request starts this one on the first stop cycle; zero payload.
        pl_q.delete();
        burst(1'b0, 1'b0);

        pl_q = {8'hC3};
        burst(1'b1, 1'b0);

        // Reset asserted while in the data phase.
        smp();
        chk1("pre_busy", BUSY, 1'b0);
        adv();
        bus.TX_REQ = 1'b1;
        adv();
        bus.TX_REQ = 1'b0;
        repeat (SYNC_C) adv();
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = 8'h42;
        smp();
        chk1("mid_ready", bus.TX_READY, 1'b1);
        adv();
        smp();
        chk8("mid_byte", HS_DATA, 8'h42);
        chk1("mid_hs_en", HS_EN, 1'b1);
        #2;
        RESET_n = 1'b0;
        #1;
        chk2("mid_rst_lp", {LP_P, LP_N}, 2'b11);
        chk1("mid_rst_hs_en", HS_EN, 1'b0);
        chk1("mid_rst_hs_mode", HS_MODE, 1'b0);
        chk8("mid_rst_hs_data", HS_DATA, 8'h00);
        chk1("mid_rst_busy", BUSY, 1'b0);
        chk1("mid_rst_ready", bus.TX_READY, 1'b0);
        bus.TX_VALID = 1'b0;
        adv();
        RESET_n = 1'b1;
        exp_uf = 1'b0;
        adv();
        smp();
        chk2("post_rst_lp", {LP_P, LP_N}, 2'b11);
        chk1("post_rst_busy", BUSY, 1'b0);
        chk_uf("post_rst_uf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
